// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one output-BRAM write port among NUM_REQ writeback producers; counts writes per job.
// Optional per-requester stall counters when WB_ARB_STALL_CNT_EN is defined.
module wb_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int WE_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [CNT_WIDTH-1:0]             expected_writes,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*WE_WIDTH-1:0]      req_strb,
  output logic                             bram_clk,
  output logic                             bram_rst,
  output logic                             bram_en,
  output logic [WE_WIDTH-1:0]              bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_din,
  output logic [CNT_WIDTH-1:0]             write_count,
`ifdef WB_ARB_STALL_CNT_EN
  output logic [NUM_REQ*CNT_WIDTH-1:0]     stall_count,
`endif
  output logic                             busy,
  output logic                             done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_en;
  logic [WE_WIDTH-1:0]   r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_done;

  logic [NUM_REQ-1:0]    w_rot;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic                  w_any;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [WE_WIDTH-1:0]   w_strb;

  // Rotate so bit 0 is the requester at the pointer; the first set bit wins.
  always_comb begin
    w_rot   = NUM_REQ'({req_valid, req_valid} >> r_ptr);
    w_any   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_win = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    if (clear) w_any = 1'b0;
    if (w_any) w_grant[w_win] = 1'b1;
    w_ptr_nxt = PTR_W'((int'(w_win) + 1) % NUM_REQ);
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr = w_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_strb = w_strb | req_strb[i*WE_WIDTH +: WE_WIDTH];
      end
    end
  end

  // A zero job length never matches, so the counter simply wraps.
  assign w_last = (expected_writes != '0) && (r_cnt == expected_writes - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
      r_done <= 1'b0;
    end else if (clear) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_we   <= '0;
      r_done <= 1'b0;
    end else begin
      r_en   <= w_any;
      r_we   <= w_any ? w_strb : '0;
      r_done <= w_any && w_last;
      if (w_any) begin
        r_addr <= w_addr;
        r_din  <= w_data;
        r_ptr  <= w_ptr_nxt;
        r_cnt  <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
      end
    end
  end

`ifdef WB_ARB_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stall
    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        r_stall[g] <= '0;
      end else if (req_valid[g] && !w_grant[g] && (r_stall[g] != '1)) begin
        r_stall[g] <= r_stall[g] + CNT_WIDTH'(1);
      end
    end
    assign stall_count[g*CNT_WIDTH +: CNT_WIDTH] = r_stall[g];
  end
`endif

  assign req_ready   = w_grant;
  assign bram_clk    = clk;
  assign bram_rst    = ~rst_n;
  assign bram_en     = r_en;
  assign bram_we     = r_we;
  assign bram_addr   = r_addr;
  assign bram_din    = r_din;
  assign write_count = r_cnt;
  assign busy        = (r_cnt != '0) | r_en;
  assign done        = r_done;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares a single 64-bit output-BRAM write port between NUM_REQ writeback producers using round-robin arbitration. Producers are PE lanes or per-bank writeback sequencers.
- Counts accepted writes against a programmed total and pulses done on the final BRAM write.
- Sits between the matmul writeback stage and the output BRAM. It replaces per-lane dedicated BRAM ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 64, write data width
- ADDR_WIDTH, 32, BRAM byte address width
- WE_WIDTH, 8, byte-enable width (DATA_WIDTH/8)
- CNT_WIDTH, 16, write counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- clear  in  1  synchronous soft clear of counter and pointer
- expected_writes  in  CNT_WIDTH  writes per job; sampled every cycle
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant/accept
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*WE_WIDTH  packed byte enables
- bram_clk  out  1  equals clk
- bram_rst  out  1  equals ~rst_n
- bram_en  out  1  BRAM enable
- bram_we  out  WE_WIDTH  BRAM byte write enable
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_din  out  DATA_WIDTH  BRAM write data
- write_count  out  CNT_WIDTH  accepted writes in the current job
- busy  out  1  job in progress
- done  out  1  one-cycle pulse on the last write

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: bram_en=0, bram_we=0, bram_addr=0, bram_din=0, write_count=0, done=0, RR pointer=0.
- Arbitration (combinational):
  - Scan starts at the RR pointer p; the first i with req_valid[i] wins.
  - req_ready is one-hot on the winner, or all zero if no request is valid.
  - At most one transfer per cycle. The BRAM never back-pressures.
- Transfer: occurs when req_valid[i] and req_ready[i] are both high.
  - After a transfer to i, the pointer becomes (i+1) mod NUM_REQ. With no transfer, the pointer holds.
- Requester rule: addr, data and strb stay stable while valid is high and ready is low. Valid must not drop before the transfer.
- Output stage: registered, 1-cycle latency.
  - Cycle after a transfer: bram_en=1, bram_we=strb, bram_addr=addr, bram_din=data.
  - Cycle after no transfer: bram_en=0 and bram_we=0. bram_addr and bram_din hold their last values.
  - A transfer with strb=0 is still accepted, counted and issued (en=1, we=0).
- Counter:
  - Increments on each transfer.
  - If a transfer occurs while write_count == expected_writes-1: write_count returns to 0, and done pulses 1 in the same cycle as the final bram_en.
  - expected_writes=0: done never asserts; write_count wraps modulo 2^CNT_WIDTH.
  - Changing expected_writes mid-job is legal; the compare uses the current value.
- busy = (write_count != 0) | bram_en.
- clear, when high:
  - req_ready=0 (no transfer that cycle).
  - Next cycle: write_count=0, pointer=0, bram_en=0, bram_we=0, done=0.
  - clear overrides a would-be final transfer: no done is produced.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-flight output write is dropped.
- Simultaneous requests: a requester with valid continuously asserted waits at most NUM_REQ-1 cycles.

Optional Feature:
- Macro: WB_ARB_STALL_CNT_EN
- Defined: adds output stall_count (NUM_REQ*CNT_WIDTH).
  - Per-requester counter increments each cycle where req_valid[i]=1 and req_ready[i]=0, including cycles blocked by clear.
  - Saturates at all-ones.
  - Zeroed by reset or clear. Not cleared by done.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Single requester: expected_writes=3; req0 writes addr 0x00, 0x08, 0x10 back-to-back -> req_ready0=1 each cycle. bram_en=1 for 3 cycles, 1 cycle after each accept, with matching addr/din/we. done=1 with the third write; write_count 1,2,0.
- Contention: req0 and req1 valid continuously from reset (pointer 0), 4 writes each -> grants alternate 0,1,0,1,... bram_addr sequence matches. Each requester waits no more than 1 cycle.
- Idle gaps and strb: req1 one write with strb=8'h0F, then 3 idle cycles -> one bram_en pulse with we=8'h0F. Then en=0 and we=0, with addr/din held.
- Clear mid-job: expected_writes=4; after 2 writes assert clear with req0 valid -> req_ready=0 that cycle. write_count=0 next cycle, no done. 4 further writes then produce done.
- Reset mid-job: rst_n low for 1 cycle during a contended burst -> next cycle all outputs at reset values. The pointer restarts at req0.
- WB_ARB_STALL_CNT_EN: req0 and req1 valid together for 6 cycles -> stall_count = 3 for each. clear zeroes both.
